// File: rtl/fcn_pkg.sv
// ============================================================================
// Module  : fcn_pkg
// Brief   : Shared FSM state type and default sizing for the fully-connected
//           neuron MAC/accumulate block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fcn_pkg;

  localparam int FCN_DATA_WIDTH = 32;
  localparam int FCN_ADDR_WIDTH = 12;
  localparam int FCN_FRAC_BITS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fcn_sat_relu.sv
// ============================================================================
// Module  : fcn_sat_relu
// Brief   : Requantises the wide accumulator back to a DATA_WIDTH fixed-point
//           word: arithmetic shift by FRAC_BITS, signed saturation, optional
//           ReLU. overflow reports saturation before ReLU is applied.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fcn_sat_relu #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 76,
  parameter int FRAC_BITS  = 16
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic                         relu_en,
  output logic        [DATA_WIDTH-1:0] data,
  output logic                         overflow
);

  logic signed [ACC_WIDTH-1:0]          shifted;
  logic        [ACC_WIDTH-DATA_WIDTH:0] upper;
  logic        [DATA_WIDTH-1:0]         clipped;

  // Shift out the fraction, clip to the signed output range, then apply ReLU
  always_comb begin
    shifted  = acc >>> FRAC_BITS;
    // The value fits only when every bit from the output sign bit upward agrees
    upper    = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
    overflow = !((&upper) || !(|upper));
    if (overflow) begin
      clipped = shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      clipped = shifted[DATA_WIDTH-1:0];
    end
    data = (relu_en && clipped[DATA_WIDTH-1]) ? '0 : clipped;
  end

endmodule

`default_nettype wire

// File: rtl/fcn_mac_accum.sv
// ============================================================================
// Module  : fcn_mac_accum
// Brief   : Streaming multiply-accumulate for one neuron: N paired beats of
//           input x weight are summed onto a bias, requantised and offered
//           as a single result word on a valid/ready output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fcn_mac_accum
  import fcn_pkg::*;
#(
  parameter int DATA_WIDTH = FCN_DATA_WIDTH,
  parameter int ADDR_WIDTH = FCN_ADDR_WIDTH,
  parameter int FRAC_BITS  = FCN_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_num_cnt,
  input  logic [DATA_WIDTH-1:0] i_bias,
  input  logic                  i_relu_en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_input,
  input  logic [DATA_WIDTH-1:0] s_weight,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  o_idle,
  output logic                  o_done,
  output logic                  o_overflow
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  // Headroom of ADDR_WIDTH bits lets up to 2**ADDR_WIDTH full-scale products
  // sum without wrapping.
  localparam int ACC_WIDTH  = PROD_WIDTH + ADDR_WIDTH;

  state_t                       state;
  state_t                       next_state;
  logic [ADDR_WIDTH-1:0]        num_beats;
  logic [ADDR_WIDTH-1:0]        cnt;
  logic                         relu_en;
  logic                         ovf_held;
  logic                         prod_valid;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [PROD_WIDTH-1:0] prod_next;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic                         start;
  logic                         beat;
  logic [DATA_WIDTH-1:0]        sat_data;
  logic                         sat_ovf;

  assign start     = (state == ST_IDLE) && i_start;
  assign beat      = s_valid && s_ready;
  assign bias_ext  = ACC_WIDTH'($signed(i_bias)) <<< FRAC_BITS;
  assign prod_next = $signed({{DATA_WIDTH{s_input[DATA_WIDTH-1]}}, s_input}) *
                     $signed({{DATA_WIDTH{s_weight[DATA_WIDTH-1]}}, s_weight});

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    o_idle     = 1'b0;
    o_done     = 1'b0;
    case (state)
      ST_IDLE: begin
        o_idle = 1'b1;
        if (i_start) begin
          next_state = (i_num_cnt == '0) ? ST_OUTPUT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        s_ready = 1'b1;
        if (s_valid && (cnt == num_beats - ADDR_WIDTH'(1))) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave on the edge that folds the final product into acc
        if (prod_valid) begin
          next_state = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Two-stage MAC pipeline, beat counter, latched configuration, sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_beats  <= '0;
      relu_en    <= 1'b0;
      cnt        <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
      ovf_held   <= 1'b0;
    end else begin
      prod_valid <= beat;
      if (beat) begin
        prod <= prod_next;
        cnt  <= cnt + ADDR_WIDTH'(1);
      end
      if (start) begin
        num_beats <= i_num_cnt;
        relu_en   <= i_relu_en;
        acc       <= bias_ext;
        cnt       <= '0;
        ovf_held  <= 1'b0;
      end else if (prod_valid) begin
        acc <= acc + ACC_WIDTH'(prod);
      end
      if (m_valid && sat_ovf) begin
        ovf_held <= 1'b1;
      end
    end
  end

  fcn_sat_relu #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_sat_relu (
    .acc      (acc),
    .relu_en  (relu_en),
    .data     (sat_data),
    .overflow (sat_ovf)
  );

  // The overflow flag is visible as soon as the result is, then held
  assign m_data     = m_valid ? sat_data : '0;
  assign o_overflow = ovf_held || (m_valid && sat_ovf);

endmodule

`default_nettype wire

// File: tb/tb_fcn_mac_accum.sv
// ============================================================================
// Module  : tb_fcn_mac_accum
// Brief   : Self-checking bench for fcn_mac_accum with a wide-integer
//           reference model of the neuron result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fcn_mac_accum;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_start = 1'b0;
  logic [11:0] i_num_cnt = '0;
  logic [31:0] i_bias = '0;
  logic        i_relu_en = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_input = '0;
  logic [31:0] s_weight = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        o_idle;
  logic        o_done;
  logic        o_overflow;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] in_q[$];
  logic [31:0] w_q[$];

  // Results of the most recent job
  logic [31:0] r_data, r_data_after;
  logic        r_ovf, r_timeout, r_stable, r_idle;
  int          r_beats, r_ready_seen, r_latency, r_done_cnt;

  fcn_mac_accum #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (12),
    .FRAC_BITS  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_num_cnt  (i_num_cnt),
    .i_bias     (i_bias),
    .i_relu_en  (i_relu_en),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_input    (s_input),
    .s_weight   (s_weight),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .o_idle     (o_idle),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  // Reference: exact sum in Q.16, floor shift, clip, ReLU
  function automatic void model(input int n, input logic [31:0] bias, input logic relu,
                                output logic [31:0] d, output logic ov);
    logic signed [127:0] tot, q;
    tot = 128'($signed(bias)) * 128'sd65536;
    for (int i = 0; i < n; i++) tot = tot + 128'($signed(in_q[i])) * 128'($signed(w_q[i]));
    q  = tot >>> 16;
    ov = 1'b0;
    if (q > 128'sd2147483647) begin
      d = 32'h7FFF_FFFF; ov = 1'b1;
    end else if (q < -128'sd2147483648) begin
      d = 32'h8000_0000; ov = 1'b1;
    end else begin
      d = q[31:0];
    end
    if (relu && d[31]) d = '0;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic signed [31:0] v;
    v = $signed($urandom);
    return v >>> $urandom_range(20, 0);
  endfunction

  // Drives one complete job and records what the DUT did
  task automatic run_job(input int n, input logic [31:0] bias, input logic relu,
                         input int gap_pct, input int stall, input bit poke);
    int cyc, acc_cyc;
    r_beats = 0; r_ready_seen = 0; r_timeout = 1'b0; r_latency = -1;
    r_stable = 1'b1; r_done_cnt = 0;
    @(posedge clk); #1;
    i_start = 1'b1; i_num_cnt = 12'(n); i_bias = bias; i_relu_en = relu;
    @(posedge clk); #1;
    i_start = 1'b0; i_num_cnt = 12'($urandom); i_bias = $urandom; i_relu_en = ~relu;
    cyc = 0; acc_cyc = -100;
    while (!m_valid && cyc < 300) begin
      if (r_beats < n) begin
        s_valid  = ($urandom_range(99) >= gap_pct);
        s_input  = in_q[r_beats];
        s_weight = w_q[r_beats];
      end else begin
        s_valid  = poke;
        s_input  = $urandom;
        s_weight = $urandom;
      end
      if (poke) i_start = 1'($urandom_range(1));
      if (s_ready) r_ready_seen++;
      if (s_valid && s_ready) begin
        r_beats++;
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; i_start = 1'b0;
    if (!m_valid) begin
      r_timeout = 1'b1;
      reset = 1'b0; #2; reset = 1'b1;
      return;
    end
    r_latency = cyc - acc_cyc;
    r_data = m_data;
    r_ovf  = o_overflow;
    m_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!m_valid || m_data !== r_data) r_stable = 1'b0;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (3) begin
      if (o_done) r_done_cnt++;
      @(posedge clk); #1;
    end
    r_idle = o_idle;
    r_data_after = m_data;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({s_ready, m_valid, o_done, o_overflow, o_idle} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00001", {s_ready, m_valid, o_done, o_overflow, o_idle});
    end
    n_cmp++;
    if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_mdata: got %h want 0", m_data); end
    reset = 1'b1;
  endtask

  task automatic test_unit_gain();
    in_q = {}; w_q = {};
    repeat (4) begin in_q.push_back(32'h0001_0000); w_q.push_back(32'h0000_8000); end
    run_job(4, 32'h0, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL unit_timeout: got %b want 0", r_timeout); end
    n_cmp++; if (r_data !== 32'h0002_0000) begin n_fail++; $display("FAIL unit_data: got %h want 00020000", r_data); end
    n_cmp++; if (r_latency !== 2) begin n_fail++; $display("FAIL unit_latency: got %0d want 2", r_latency); end
    n_cmp++; if (r_done_cnt !== 1) begin n_fail++; $display("FAIL unit_done: got %0d want 1", r_done_cnt); end
    n_cmp++; if (r_beats !== 4) begin n_fail++; $display("FAIL unit_beats: got %0d want 4", r_beats); end
    n_cmp++; if (r_idle !== 1'b1 || r_data_after !== 32'h0) begin
      n_fail++; $display("FAIL unit_after: idle %b mdata %h want 1 0", r_idle, r_data_after);
    end
  endtask

  task automatic test_relu();
    in_q = {32'h0001_0000, 32'h0001_0000};
    w_q  = {32'hFFFD_0000, 32'hFFFD_0000};
    for (int r = 0; r < 2; r++) begin
      run_job(2, 32'h0001_0000, 1'(r), 0, 0, 1'b0);
      n_cmp++;
      if (r_data !== ((r == 0) ? 32'hFFFB_0000 : 32'h0)) begin
        n_fail++; $display("FAIL relu%0d_data: got %h want %h", r, r_data, (r == 0) ? 32'hFFFB_0000 : 32'h0);
      end
      n_cmp++; if (r_ovf !== 1'b0) begin n_fail++; $display("FAIL relu%0d_ovf: got %b want 0", r, r_ovf); end
    end
  endtask

  task automatic test_saturate();
    in_q = {32'h7FFF_0000, 32'h7FFF_0000};
    w_q  = {32'h7FFF_0000, 32'h7FFF_0000};
    run_job(2, 32'h0, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (r_data !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_data: got %h want 7fffffff", r_data); end
    n_cmp++; if (r_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", r_ovf); end
    n_cmp++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_held: got %b want 1", o_overflow); end
  endtask

  task automatic test_zero_beats();
    in_q = {}; w_q = {};
    run_job(0, 32'h0003_0000, 1'b0, 0, 0, 1'b1);
    n_cmp++; if (r_data !== 32'h0003_0000) begin n_fail++; $display("FAIL zero_data: got %h want 00030000", r_data); end
    n_cmp++; if (r_ready_seen !== 0 || r_beats !== 0) begin
      n_fail++; $display("FAIL zero_ready: ready cycles %0d beats %0d want 0 0", r_ready_seen, r_beats);
    end
    n_cmp++; if (r_ovf !== 1'b0) begin n_fail++; $display("FAIL zero_ovf: got %b want 0", r_ovf); end
  endtask

  task automatic test_stall();
    logic [31:0] ed; logic eo;
    in_q = {}; w_q = {};
    for (int i = 0; i < 3; i++) begin
      in_q.push_back(32'($signed(20'($urandom)))); w_q.push_back(32'($signed(20'($urandom))));
    end
    model(3, 32'hFFFF_8000, 1'b0, ed, eo);
    run_job(3, 32'hFFFF_8000, 1'b0, 50, 5, 1'b1);
    n_cmp++; if (r_beats !== 3) begin n_fail++; $display("FAIL stall_beats: got %0d want 3", r_beats); end
    n_cmp++; if (r_stable !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got %b want 1", r_stable); end
    n_cmp++; if (r_data !== ed) begin n_fail++; $display("FAIL stall_data: got %h want %h", r_data, ed); end
    n_cmp++; if (r_done_cnt !== 1) begin n_fail++; $display("FAIL stall_done: got %0d want 1", r_done_cnt); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    i_start = 1'b1; i_num_cnt = 12'd4; i_bias = 32'h0005_0000; i_relu_en = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    s_valid = 1'b1; s_input = 32'h0002_0000; s_weight = 32'h0003_0000;
    repeat (2) begin @(posedge clk); #1; end
    s_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({s_ready, m_valid, o_done, o_overflow, o_idle} !== 5'b00001 || m_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: flags %b mdata %h want 00001 0",
               {s_ready, m_valid, o_done, o_overflow, o_idle}, m_data);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    in_q = {32'h0001_0000}; w_q = {32'h0001_0000};
    run_job(1, 32'h0, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (r_data !== 32'h0001_0000) begin n_fail++; $display("FAIL midreset_data: got %h want 00010000", r_data); end
    n_cmp++; if (r_beats !== 1) begin n_fail++; $display("FAIL midreset_beats: got %0d want 1", r_beats); end
  endtask

  task automatic test_random();
    logic [31:0] ed, bias; logic eo, relu; int n;
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(6, 1);
      bias = rnd_word();
      relu = 1'($urandom_range(1));
      in_q = {}; w_q = {};
      for (int i = 0; i < n; i++) begin in_q.push_back(rnd_word()); w_q.push_back(rnd_word()); end
      model(n, bias, relu, ed, eo);
      run_job(n, bias, relu, 30, $urandom_range(3), 1'($urandom_range(1)));
      n_cmp++;
      if (r_data !== ed || r_ovf !== eo) begin
        n_fail++; $display("FAIL rand%0d_result: got %h/%b want %h/%b", j, r_data, r_ovf, ed, eo);
      end
      n_cmp++;
      if (r_beats !== n || r_latency !== 2) begin
        n_fail++; $display("FAIL rand%0d_timing: beats %0d lat %0d want %0d 2", j, r_beats, r_latency, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unit_gain();
    test_relu();
    test_saturate();
    test_zero_beats();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fcn_mac_accum.md
FCN_MAC_ACCUM -- requirements
Module: fcn_mac_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed width of input, weight, bias and result words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: width of the beat count.
REQ-003 SHALL have parameter FRAC_BITS, default 16: all data words are Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
REQ-004 SHALL have ports: clk in 1, single clock; reset in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: i_start in 1, start pulse; i_num_cnt in ADDR_WIDTH, beat count N; i_bias in DATA_WIDTH, neuron bias; i_relu_en in 1, ReLU enable.
REQ-006 SHALL have ports: s_valid in 1; s_ready out 1; s_input in DATA_WIDTH; s_weight in DATA_WIDTH, the paired operand stream from the data mover.
REQ-007 SHALL have ports: m_valid out 1; m_ready in 1; m_data out DATA_WIDTH, the result toward BRAM C.
REQ-008 SHALL have ports: o_idle out 1; o_done out 1, one-cycle pulse; o_overflow out 1, saturation flag.

Function
REQ-009 SHALL implement an FSM with states IDLE, ACCUM, DRAIN, OUTPUT and DONE.
REQ-010 In IDLE, i_start SHALL latch N, i_relu_en and i_bias, load acc with bias<<FRAC_BITS (sign-extended), clear cnt and o_overflow, and go to ACCUM, or go to OUTPUT if N==0.
REQ-011 i_start SHALL be ignored outside IDLE.
REQ-012 s_ready SHALL be 1 only in ACCUM; a beat is accepted on s_valid&&s_ready; gaps in s_valid are allowed.
REQ-013 Stage 1 SHALL register the full signed product (2*DATA_WIDTH bits) of an accepted beat together with prod_valid.
REQ-014 Stage 2 SHALL add a valid product to acc on the following edge; acc width SHALL be 2*DATA_WIDTH+ADDR_WIDTH so that acc never wraps.
REQ-015 On acceptance of beat N (cnt==N-1), the FSM SHALL go to DRAIN and s_ready SHALL drop on the next cycle.
REQ-016 DRAIN SHALL transition to OUTPUT on the edge that accumulates the last product, so m_valid rises exactly 2 cycles after the last accepted beat.
REQ-017 Result: acc arithmetic-shifted right by FRAC_BITS, then saturated to the signed DATA_WIDTH range; when saturation occurs, o_overflow SHALL be set and held until the next start.
REQ-018 With i_relu_en set, a negative saturated result SHALL become 0; o_overflow SHALL still reflect saturation.
REQ-019 In OUTPUT, m_valid SHALL be 1 and m_data SHALL stay stable until m_valid&&m_ready; that handshake SHALL move the FSM to DONE.
REQ-020 DONE SHALL last one cycle with o_done=1, then return to IDLE; o_idle SHALL be 1 only in IDLE.
REQ-021 m_data SHALL be 0 whenever m_valid is 0.

Reset
REQ-022 reset low SHALL asynchronously force state IDLE, and clear acc, cnt, prod_valid and all latched configuration.
REQ-023 Output values under reset SHALL be: s_ready=0, m_valid=0, m_data=0, o_done=0, o_overflow=0, o_idle=1.
REQ-024 Reset asserted mid-operation SHALL abandon the partial sum; the next i_start after reset release SHALL behave as a fresh run.

Structure
REQ-025 Shared package fcn_pkg SHALL hold the FSM state enum typedef and the default DATA_WIDTH, ADDR_WIDTH and FRAC_BITS constants.
REQ-026 Requantisation (shift, saturate, ReLU, overflow flag) SHALL be a combinational sub-module fcn_sat_relu.
REQ-027 The multiplier, accumulator, counter and FSM SHALL remain in fcn_mac_accum.

Verification
REQ-028 N=4, each beat input 0x00010000 and weight 0x00008000, bias 0 -> m_data 0x00020000; m_valid rises 2 cycles after beat 4; o_done pulses once.
REQ-029 N=2, inputs 0x00010000, weights 0xFFFD0000, bias 0x00010000: with relu_en=0 -> m_data 0xFFFB0000; with relu_en=1 -> m_data 0; o_overflow=0 in both cases.
REQ-030 N=2, input and weight both 0x7FFF0000 -> m_data 0x7FFFFFFF and o_overflow=1.
REQ-031 N=0, bias 0x00030000 -> s_ready never asserts; m_data 0x00030000.
REQ-032 N=3 with s_valid gaps and m_ready held low for 5 cycles -> exactly 3 beats accepted; m_data stable throughout the stall; extra i_start pulses while busy are ignored.
REQ-033 reset asserted in ACCUM after 2 of 4 beats -> all outputs return to their reset values immediately; a new start with N=1, input 0x00010000, weight 0x00010000 -> m_data 0x00010000.
